// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between a CPU and an IO requester.
// Each access takes two cycles: grant/latch in IDLE, then complete with a one-cycle ACK.
module mem_port_arbiter #(
    parameter int unsigned MEM_SIZE = 200,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU side
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_err,
    // IO side
    input  logic              i_io_req,
    input  logic              i_io_we,
    input  logic [ADDR_W-1:0] i_io_addr,
    input  logic [DATA_W-1:0] i_io_wdata,
    output logic              o_io_ack,
    output logic [DATA_W-1:0] o_io_rdata,
    output logic              o_io_err,
    // Memory side
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Grant identity encoding: 0 = CPU, 1 = IO
    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_IO  = 1'b1;

    state_t r_state;
    logic   r_last_gnt;
    logic   r_gnt;
    logic   r_err;

    logic              w_cpu_elig;
    logic              w_io_elig;
    logic              w_any_elig;
    logic              w_gnt_io;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic              w_oob;

    // A request whose ACK is currently high is the one retiring, so it is not eligible.
    assign w_cpu_elig = i_cpu_req & ~o_cpu_ack;
    assign w_io_elig  = i_io_req  & ~o_io_ack;
    assign w_any_elig = w_cpu_elig | w_io_elig;

    // IO wins when it is alone, or on a tie when CPU was served last.
    assign w_gnt_io = w_io_elig & (~w_cpu_elig | (r_last_gnt == GNT_CPU));

    assign w_addr  = w_gnt_io ? i_io_addr  : i_cpu_addr;
    assign w_wdata = w_gnt_io ? i_io_wdata : i_cpu_wdata;
    assign w_we    = w_gnt_io ? i_io_we    : i_cpu_we;
    assign w_oob   = (w_addr >= ADDR_W'(MEM_SIZE));

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= GNT_IO;
            r_gnt       <= GNT_CPU;
            r_err       <= 1'b0;
            o_cpu_ack   <= 1'b0;
            o_cpu_rdata <= '0;
            o_cpu_err   <= 1'b0;
            o_io_ack    <= 1'b0;
            o_io_rdata  <= '0;
            o_io_err    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_we    <= 1'b0;
        end else begin
            // ACK/ERR are single-cycle pulses.
            o_cpu_ack <= 1'b0;
            o_cpu_err <= 1'b0;
            o_io_ack  <= 1'b0;
            o_io_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_elig) begin
                        r_gnt       <= w_gnt_io;
                        r_last_gnt  <= w_gnt_io;
                        o_mem_addr  <= w_addr;
                        o_mem_wdata <= w_wdata;
                        o_mem_we    <= w_we & ~w_oob;
                        r_err       <= w_oob;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Memory has written on the intervening negedge; read data reflects it.
                    if (r_gnt == GNT_IO) begin
                        o_io_ack   <= 1'b1;
                        o_io_err   <= r_err;
                        o_io_rdata <= r_err ? DATA_W'(0) : i_mem_rdata;
                    end else begin
                        o_cpu_ack   <= 1'b1;
                        o_cpu_err   <= r_err;
                        o_cpu_rdata <= r_err ? DATA_W'(0) : i_mem_rdata;
                    end
                    o_mem_we <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// concurrent CPU/IO traffic checked against a transaction-level memory model.
module tb_mem_port_arbiter;

    localparam int MEM_SIZE = 200;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic        cpu_ack, cpu_err, io_ack, io_err;
    logic [15:0] cpu_rdata, io_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int total = 0;
    int bad   = 0;

    // Physical memory attached to the DUT and the bench's independent expectation of it.
    logic [15:0] mem     [MEM_SIZE];
    logic [15:0] ref_mem [MEM_SIZE];

    mem_port_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_err(cpu_err),
        .i_io_req(io_req), .i_io_we(io_we), .i_io_addr(io_addr), .i_io_wdata(io_wdata),
        .o_io_ack(io_ack), .o_io_rdata(io_rdata), .o_io_err(io_err),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory writes on negedge; reads are combinational. Out-of-range reads return junk.
    always @(negedge clk) begin
        if (mem_we && int'(mem_addr) < MEM_SIZE) mem[int'(mem_addr)] <= mem_wdata;
    end
    always_comb begin
        if (int'(mem_addr) < MEM_SIZE) mem_rdata = mem[int'(mem_addr)];
        else                           mem_rdata = 16'hDEAD;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic io_drive(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        io_req = req; io_we = we; io_addr = a; io_wdata = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
        io_drive(1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        #12;
        total++;
        if ({cpu_ack, cpu_err, io_ack, io_err, mem_we} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000", {cpu_ack, cpu_err, io_ack, io_err, mem_we});
        end
        total++;
        if ({cpu_rdata, io_rdata, mem_addr, mem_wdata} !== 64'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {cpu_rdata, io_rdata, mem_addr, mem_wdata});
        end
        #5 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_write();
        cpu_drive(1'b1, 1'b1, 16'd5, 16'h1234);
        tick();
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 16'd5 || mem_wdata !== 16'h1234 || cpu_ack !== 1'b0) begin
            bad++;
            $display("FAIL cpu_wr_grant we=%b addr=%h wdata=%h ack=%b exp 1/0005/1234/0", mem_we, mem_addr, mem_wdata, cpu_ack);
        end
        tick();
        total++;
        if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 16'h1234 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL cpu_wr_ack ack=%b err=%b rdata=%h mem_we=%b exp 1/0/1234/0", cpu_ack, cpu_err, cpu_rdata, mem_we);
        end
        cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
        ref_mem[5] = 16'h1234;
        tick();
        total++;
        if (cpu_ack !== 1'b0 || mem[5] !== 16'h1234) begin
            bad++;
            $display("FAIL cpu_wr_after ack=%b mem5=%h exp 0/1234", cpu_ack, mem[5]);
        end
    endtask

    task automatic test_io_read();
        io_drive(1'b1, 1'b0, 16'd5, 16'h0);
        tick();
        tick();
        total++;
        if (io_ack !== 1'b1 || io_err !== 1'b0 || io_rdata !== 16'h1234) begin
            bad++;
            $display("FAIL io_rd ack=%b err=%b rdata=%h exp 1/0/1234", io_ack, io_err, io_rdata);
        end
        total++;
        if (cpu_ack !== 1'b0 || cpu_rdata !== 16'h1234) begin
            bad++;
            $display("FAIL io_rd_cpu_hold ack=%b rdata=%h exp 0/1234", cpu_ack, cpu_rdata);
        end
        io_drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
    endtask

    task automatic test_fairness();
        int cpu_n, io_n;
        cpu_n = 0; io_n = 0;
        cpu_drive(1'b1, 1'b1, 16'd10, 16'hAAAA);
        io_drive(1'b1, 1'b1, 16'd11, 16'h5555);
        // Last served was IO, so CPU goes first; then strict alternation every 2 cycles.
        for (int t = 1; t <= 12; t++) begin
            tick();
            total++;
            if (cpu_ack !== (t % 4 == 2) || io_ack !== (t % 4 == 0)) begin
                bad++;
                $display("FAIL fairness t=%0d cpu_ack=%b io_ack=%b exp %b/%b", t, cpu_ack, io_ack, t % 4 == 2, t % 4 == 0);
            end
            if (cpu_ack) cpu_n++;
            if (io_ack) io_n++;
        end
        cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
        io_drive(1'b0, 1'b0, 16'h0, 16'h0);
        ref_mem[10] = 16'hAAAA;
        ref_mem[11] = 16'h5555;
        tick();
        tick();
        total++;
        if (cpu_n != 3 || io_n != 3 || mem[10] !== 16'hAAAA || mem[11] !== 16'h5555) begin
            bad++;
            $display("FAIL fairness_total cpu=%0d io=%0d m10=%h m11=%h exp 3/3/aaaa/5555", cpu_n, io_n, mem[10], mem[11]);
        end
    endtask

    task automatic test_oob();
        cpu_drive(1'b1, 1'b1, 16'd200, 16'hBEEF);
        tick();
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL oob_we got=%b exp=0", mem_we);
        end
        tick();
        total++;
        if (cpu_ack !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 16'h0) begin
            bad++;
            $display("FAIL oob_ack ack=%b err=%b rdata=%h exp 1/1/0000", cpu_ack, cpu_err, cpu_rdata);
        end
        cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        cpu_drive(1'b1, 1'b1, 16'd199, 16'h1999);
        tick();
        tick();
        total++;
        if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 16'h1999) begin
            bad++;
            $display("FAIL edge_199 ack=%b err=%b rdata=%h exp 1/0/1999", cpu_ack, cpu_err, cpu_rdata);
        end
        ref_mem[199] = 16'h1999;
        cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        io_drive(1'b1, 1'b0, 16'hFFFF, 16'h0);
        tick();
        tick();
        total++;
        if (io_ack !== 1'b1 || io_err !== 1'b1 || io_rdata !== 16'h0) begin
            bad++;
            $display("FAIL oob_ffff ack=%b err=%b rdata=%h exp 1/1/0000", io_ack, io_err, io_rdata);
        end
        io_drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
    endtask

    task automatic test_hold_req();
        int acks;
        acks = 0;
        cpu_drive(1'b1, 1'b0, 16'd10, 16'h0);
        tick();
        tick();
        if (cpu_ack) acks++;
        // Still high through the ACK cycle, dropped only afterwards.
        tick();
        if (cpu_ack) acks++;
        cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpu_ack) acks++;
        end
        total++;
        if (acks != 1 || cpu_rdata !== 16'hAAAA) begin
            bad++;
            $display("FAIL hold_req acks=%0d rdata=%h exp 1/aaaa", acks, cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks;
        acks = 0;
        cpu_drive(1'b1, 1'b1, 16'd7, 16'h7777);
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_we got=%b exp=0", mem_we);
        end
        cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cpu_ack) acks++;
        end
        total++;
        if (acks != 0 || mem[7] !== ref_mem[7]) begin
            bad++;
            $display("FAIL rst_mid_effect acks=%0d mem7=%h exp 0/%h", acks, mem[7], ref_mem[7]);
        end
        // Back in IDLE: a fresh read is serviced with normal latency.
        cpu_drive(1'b1, 1'b0, 16'd7, 16'h0);
        tick();
        tick();
        total++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== ref_mem[7]) begin
            bad++;
            $display("FAIL rst_mid_reissue ack=%b rdata=%h exp 1/%h", cpu_ack, cpu_rdata, ref_mem[7]);
        end
        cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
        tick();
    endtask

    // One requester issuing random transactions; results predicted from the transaction model.
    task automatic agent(input bit side, input int n);
        for (int k = 0; k < n; k++) begin
            int          waited;
            bit          got;
            logic        we;
            logic [15:0] a, d, exp_rd, got_rd;
            logic        exp_err, got_err;
            repeat ($urandom_range(1, 3)) tick();
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, MEM_SIZE + 3));
            d  = 16'($urandom);
            if (side) io_drive(1'b1, we, a, d);
            else      cpu_drive(1'b1, we, a, d);
            waited = 0;
            got = 1'b0;
            while (waited < 8 && !got) begin
                tick();
                waited++;
                got = side ? io_ack : cpu_ack;
            end
            got_rd  = side ? io_rdata : cpu_rdata;
            got_err = side ? io_err : cpu_err;
            if (side) io_drive(1'b0, 1'b0, 16'h0, 16'h0);
            else      cpu_drive(1'b0, 1'b0, 16'h0, 16'h0);
            total++;
            if (!got || waited > 4) begin
                bad++;
                $display("FAIL rand_latency side=%0d got_ack=%0d edges=%0d exp ack within 4", side, got, waited);
            end else begin
                exp_err = (int'(a) >= MEM_SIZE);
                exp_rd  = exp_err ? 16'h0 : (we ? d : ref_mem[int'(a)]);
                if (we && !exp_err) ref_mem[int'(a)] = d;
                total++;
                if (got_err !== exp_err || got_rd !== exp_rd) begin
                    bad++;
                    $display("FAIL rand_data side=%0d addr=%h we=%b err=%b rdata=%h exp %b/%h", side, a, we, got_err, got_rd, exp_err, exp_rd);
                end
            end
        end
    endtask

    task automatic test_random();
        int diffs;
        fork
            agent(1'b0, 40);
            agent(1'b1, 40);
        join
        tick();
        tick();
        diffs = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (mem[i] !== ref_mem[i]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL rand_mem_image differing_words=%0d exp 0", diffs);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_io_read();
        test_fairness();
        test_oob();
        test_hold_req();
        test_reset_mid_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
